vote_result_sequencer: RTL and testbench

- Downstream consumer of the vote-count stage. In result mode it snapshots the four candidate tallies, finds the winner or a tie with a sequential comparator, then steps through each candidate's count on the display bus.
- It finishes by holding the winner.
- It sits between the vote counter and the LED/display driver, and replaces direct count-to-LED muxing.

---
 rtl/vote_result_sequencer_pkg.sv | 21 ++
 rtl/vote_result_sequencer_dwell_timer.sv | 33 +++
 rtl/vote_result_sequencer.sv | 169 ++++++++++++++++
 tb/tb_vote_result_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vote_result_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vote_pkg: shared types and constants for vote_result_sequencer           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package vote_pkg;
  localparam int NUM_CAND = 4;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_TOTAL = 3'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    SCAN = 3'd2,
    SHOW = 3'd3,
    WIN  = 3'd4
  } state_t;
endpackage
`default_nettype wire

// File: rtl/vote_result_sequencer_dwell_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dwell_timer: reloadable down-counter; expire pulses on the last cycle    |
// | of each DWELL_CYCLES-long interval.   Rev 1.0                            |
// +--------------------------------------------------------------------------+
module dwell_timer #(
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(DWELL_CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= C_LOAD;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Counting D..1 gives exactly DWELL_CYCLES cycles per interval.
  assign expire = en && (r_cnt == CW'(1));
endmodule
`default_nettype wire

// File: rtl/vote_result_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vote_result_sequencer: snapshots four tallies, finds winner/tie, steps   |
// | each count to the display, then holds the winner.                        |
// | Optional macro VOTE_TOTAL_EN adds a total output and a fifth show slot.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vote_result_sequencer
  import vote_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [CNT_W-1:0] cnt1,
  input  logic [CNT_W-1:0] cnt2,
  input  logic [CNT_W-1:0] cnt3,
  input  logic [CNT_W-1:0] cnt4,
  output logic [CNT_W-1:0] disp_data,
  output logic [2:0]       disp_sel,
  output logic [1:0]       winner_id,
  output logic             winner_valid,
  output logic             tie,
  output logic             busy
`ifdef VOTE_TOTAL_EN
  ,
  output logic [CNT_W+1:0] total
`endif
);
`ifdef VOTE_TOTAL_EN
  localparam slot_t LAST_SLOT = SLOT_TOTAL;
`else
  localparam slot_t LAST_SLOT = 3'd3;
`endif

  state_t           r_state, w_next;
  logic             r_mode_d, r_start;
  logic [CNT_W-1:0] r_snap [NUM_CAND];
  logic [CNT_W-1:0] r_best;
  logic [1:0]       r_best_idx, r_idx;
  logic             r_tie;
  slot_t            r_slot;
  logic             w_load, w_expire;

`ifdef VOTE_TOTAL_EN
  localparam logic [CNT_W+1:0] C_SAT = {2'b00, {CNT_W{1'b1}}};
  logic [CNT_W+1:0] r_total;
  logic [CNT_W-1:0] w_total_sat;
  assign w_total_sat = (r_total > C_SAT) ? {CNT_W{1'b1}} : r_total[CNT_W-1:0];
`endif

  dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .en     (r_state == SHOW),
    .expire (w_expire)
  );

  // mode_d resets high so a mode already high at reset release is not a rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_mode_d   <= 1'b1;
      r_start    <= 1'b0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_idx      <= '0;
      r_tie      <= 1'b0;
      r_slot     <= '0;
      for (int i = 0; i < NUM_CAND; i++) r_snap[i] <= '0;
`ifdef VOTE_TOTAL_EN
      r_total    <= '0;
`endif
    end else begin
      r_state  <= w_next;
      r_mode_d <= mode;
      r_start  <= mode & ~r_mode_d;
      case (r_state)
        SNAP: begin
          r_snap[0]  <= cnt1;
          r_snap[1]  <= cnt2;
          r_snap[2]  <= cnt3;
          r_snap[3]  <= cnt4;
          r_best     <= cnt1;
          r_best_idx <= 2'd0;
          r_tie      <= 1'b0;
          r_idx      <= 2'd1;
`ifdef VOTE_TOTAL_EN
          r_total    <= (CNT_W+2)'(cnt1);
`endif
        end
        SCAN: begin
          if (r_snap[r_idx] > r_best) begin
            r_best     <= r_snap[r_idx];
            r_best_idx <= r_idx;
            r_tie      <= 1'b0;
          end else if (r_snap[r_idx] == r_best) begin
            r_tie <= 1'b1;
          end
          r_idx  <= r_idx + 2'd1;
          r_slot <= '0;
`ifdef VOTE_TOTAL_EN
          r_total <= r_total + (CNT_W+2)'(r_snap[r_idx]);
`endif
        end
        SHOW: if (w_expire) r_slot <= r_slot + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    if (!mode) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (r_start) w_next = SNAP;
        SNAP: w_next = SCAN;
        SCAN: if (r_idx == 2'd3) begin
          w_next = SHOW;
          w_load = 1'b1;
        end
        SHOW: if (w_expire) begin
          if (r_slot == LAST_SLOT) w_next = WIN;
          else                     w_load = 1'b1;
        end
        WIN:     w_next = WIN;
        default: w_next = IDLE;
      endcase
    end
  end

  // Results are final once SHOW is entered, so they are gated by state.
  always_comb begin
    disp_data    = '0;
    disp_sel     = '0;
    winner_id    = '0;
    winner_valid = 1'b0;
    tie          = 1'b0;
    busy         = r_start || (r_state == SNAP) || (r_state == SCAN) || (r_state == SHOW);
`ifdef VOTE_TOTAL_EN
    total        = '0;
`endif
    if ((r_state == SHOW) || (r_state == WIN)) begin
      winner_valid = (r_best != '0);
      tie          = r_tie && (r_best != '0);
      winner_id    = (r_best != '0) ? r_best_idx : 2'd0;
`ifdef VOTE_TOTAL_EN
      total        = r_total;
`endif
    end
    if (r_state == SHOW) begin
      disp_sel  = r_slot;
      disp_data = r_snap[r_slot[1:0]];
`ifdef VOTE_TOTAL_EN
      if (r_slot == SLOT_TOTAL) disp_data = w_total_sat;
`endif
    end else if (r_state == WIN) begin
      disp_sel  = {1'b0, r_best_idx};
      disp_data = r_best;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vote_result_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vote_result_sequencer: scoreboard bench, DWELL_CYCLES=4, CNT_W=8      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vote_result_sequencer;
  localparam int DW = 4;
`ifdef VOTE_TOTAL_EN
  localparam int NSLOT = 5;
`else
  localparam int NSLOT = 4;
`endif

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } disp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] cnt1 = '0, cnt2 = '0, cnt3 = '0, cnt4 = '0;
  logic [7:0] disp_data;
  logic [2:0] disp_sel;
  logic [1:0] winner_id;
  logic       winner_valid, tie, busy;
`ifdef VOTE_TOTAL_EN
  logic [9:0] total;
`endif

  int checks = 0;
  int errors = 0;
  disp_t sb[$];

  always #5 clk = ~clk;

  vote_result_sequencer #(.CNT_W(8), .DWELL_CYCLES(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .cnt1         (cnt1),
    .cnt2         (cnt2),
    .cnt3         (cnt3),
    .cnt4         (cnt4),
    .disp_data    (disp_data),
    .disp_sel     (disp_sel),
    .winner_id    (winner_id),
    .winner_valid (winner_valid),
    .tie          (tie),
    .busy         (busy)
`ifdef VOTE_TOTAL_EN
    ,
    .total        (total)
`endif
  );

  task automatic test_reset();
    #3;
    checks++;
    if ({disp_data, disp_sel, winner_id, winner_valid, tie, busy} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {disp_data, disp_sel, winner_id, winner_valid, tie, busy});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One full result sequence; poke_cyc >= 0 changes cnt3 to 200 at that cycle.
  task automatic run_seq(input string name, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input logic [7:0] c4,
                         input logic [1:0] exp_id, input logic exp_tie,
                         input logic exp_valid, input int poke_cyc);
    logic [7:0] snap [4];
    int         busy_cnt;
    int         sum;
    disp_t      e;
    snap = '{c1, c2, c3, c4};
    sum  = int'(c1) + int'(c2) + int'(c3) + int'(c4);
    @(negedge clk);
    mode = 1'b0;
    cnt1 = c1; cnt2 = c2; cnt3 = c3; cnt4 = c4;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    for (int s = 0; s < NSLOT; s++)
      for (int d = 0; d < DW; d++)
        sb.push_back('{sel: 3'(s), data: (s == 4) ? ((sum > 255) ? 8'd255 : 8'(sum)) : snap[s]});
    sb.push_back('{sel: {1'b0, exp_id}, data: snap[exp_id]});
    sb.push_back('{sel: {1'b0, exp_id}, data: snap[exp_id]});
    mode = 1'b1;
    busy_cnt = 0;
    for (int cyc = 0; cyc <= 6 + NSLOT * DW; cyc++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (cyc == poke_cyc) cnt3 = 8'd200;
      if (cyc == 4) begin
        checks++;
        if (winner_valid !== 1'b0 || tie !== 1'b0) begin
          errors++;
          $display("FAIL %s early_result: valid=%b tie=%b expected 0 before N+5", name, winner_valid, tie);
        end
      end
      if (cyc == 5) begin
        checks++;
        if ({winner_id, tie, winner_valid} !== {exp_id, exp_tie, exp_valid}) begin
          errors++;
          $display("FAIL %s result: id=%0d tie=%b valid=%b expected id=%0d tie=%b valid=%b",
                   name, winner_id, tie, winner_valid, exp_id, exp_tie, exp_valid);
        end
`ifdef VOTE_TOTAL_EN
        checks++;
        if (total !== 10'(sum)) begin
          errors++;
          $display("FAIL %s total: got %0d expected %0d", name, total, sum);
        end
`endif
      end
      if (cyc >= 5) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard_empty at cycle %0d", name, cyc);
        end else begin
          e = sb.pop_front();
          if (disp_sel !== e.sel || disp_data !== e.data) begin
            errors++;
            $display("FAIL %s display cyc %0d: sel=%0d data=%0d expected sel=%0d data=%0d",
                     name, cyc, disp_sel, disp_data, e.sel, e.data);
          end
        end
      end
    end
    checks++;
    if (busy_cnt != 5 + NSLOT * DW) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, 5 + NSLOT * DW);
    end
    checks++;
    if ({winner_id, tie, winner_valid} !== {exp_id, exp_tie, exp_valid}) begin
      errors++;
      $display("FAIL %s win_hold: id=%0d tie=%b valid=%b", name, winner_id, tie, winner_valid);
    end
  endtask

  task automatic test_mode_drop();
    @(negedge clk);
    mode = 1'b0;
    cnt1 = 8'd10; cnt2 = 8'd2; cnt3 = 8'd15; cnt4 = 8'd1;
    @(negedge clk);
    @(negedge clk);
    mode = 1'b1;
    for (int cyc = 0; cyc <= 14; cyc++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (disp_sel !== 3'd2 || disp_data !== 8'd15 || winner_id !== 2'd2) begin
      errors++;
      $display("FAIL mode_drop_slot2: sel=%0d data=%0d id=%0d expected 2/15/2", disp_sel, disp_data, winner_id);
    end
    @(negedge clk);
    mode = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({disp_data, disp_sel, winner_id, winner_valid, tie, busy} !== 16'h0) begin
      errors++;
      $display("FAIL mode_drop_clear: got %h expected 0",
               {disp_data, disp_sel, winner_id, winner_valid, tie, busy});
    end
    run_seq("mode_rerise", 8'd10, 8'd20, 8'd15, 8'd1, 2'd1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_async_reset();
    int spur;
    @(negedge clk);
    mode = 1'b0;
    cnt1 = 8'd5; cnt2 = 8'd6; cnt3 = 8'd7; cnt4 = 8'd8;
    @(negedge clk);
    @(negedge clk);
    mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_busy: got %b expected 1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({disp_data, disp_sel, winner_id, winner_valid, tie, busy} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_clear: got %h expected 0",
               {disp_data, disp_sel, winner_id, winner_valid, tie, busy});
    end
    @(negedge clk);
    reset = 1'b1;
    spur = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (busy || winner_valid || disp_data != 8'd0) spur++;
    end
    checks++;
    if (spur != 0) begin
      errors++;
      $display("FAIL async_no_restart: %0d active cycles expected 0", spur);
    end
    run_seq("async_restart", 8'd5, 8'd6, 8'd7, 8'd8, 2'd3, 1'b0, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    run_seq("clear_winner", 8'd3, 8'd9, 8'd5, 8'd1, 2'd1, 1'b0, 1'b1, -1);
    run_seq("tie",          8'd7, 8'd2, 8'd7, 8'd7, 2'd0, 1'b1, 1'b1, -1);
    run_seq("tie_broken",   8'd4, 8'd4, 8'd6, 8'd0, 2'd2, 1'b0, 1'b1, -1);
    run_seq("all_zero",     8'd0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, -1);
    test_mode_drop();
    test_async_reset();
    run_seq("snap_isolation", 8'd3, 8'd9, 8'd5, 8'd1, 2'd1, 1'b0, 1'b1, 8);
`ifdef VOTE_TOTAL_EN
    run_seq("total_sat", 8'd200, 8'd100, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1, -1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
